// File: rtl/sram_dp_param.sv
// sram_dp_param: simple-dual-port SRAM with one write port and one read port.
// It supports byte-masked writes and a 1- or 2-cycle registered read with rvalid.
// A write/read collision policy is selectable at build time.
// When INIT_ZERO is set, an optional sweep zero-fills every word after reset.
module sram_dp_param #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 8192,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int READ_LAT    = 1,
  parameter bit WRITE_FIRST = 1'b1,
  parameter bit INIT_ZERO   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wsbn,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W/8-1:0] wmask,
  input  logic              csbn,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              init_done
);

  localparam int BYTES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] cnt;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [BYTES-1:0]  wr_be;
  logic              rd_en;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] mem [DEPTH];

  // State register plus sweep counter; reset always restarts the sweep from word 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Leave INIT after the last word is cleared, or immediately when no sweep is wanted
  always_comb begin
    state_next = state;
    case (state)
      INIT: begin
        if (!INIT_ZERO || (cnt == LAST_ADDR)) begin
          state_next = READY;
        end
      end
      READY: state_next = READY;
      default: state_next = INIT;
    endcase
  end

  // Steer the single write port to the sweep or the user, and gate reads until ready
  always_comb begin
    init_done = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = waddr;
    wr_data   = wdata;
    wr_be     = wmask;
    rd_en     = 1'b0;
    case (state)
      INIT: begin
        if (INIT_ZERO) begin
          wr_en   = 1'b1;
          wr_addr = cnt;
          wr_data = '0;
          wr_be   = '1;
        end
      end
      READY: begin
        init_done = 1'b1;
        wr_en     = !wsbn;
        rd_en     = !csbn;
      end
      default: ;
    endcase
  end

  // Byte-masked array write; contents are deliberately left alone by reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_be[b]) begin
          mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read word seen by a request this cycle, with write data forwarded on a write-first collision
  always_comb begin
    rd_word = mem[raddr];
    if (WRITE_FIRST && wr_en && (wr_addr == raddr)) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_be[b]) begin
          rd_word[8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] s1_data;
      logic              s1_valid;

      // Two-stage read pipeline; reset drops anything in flight
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_data  <= '0;
          s1_valid <= 1'b0;
          rdata    <= '0;
          rvalid   <= 1'b0;
        end else begin
          s1_valid <= rd_en;
          if (rd_en) begin
            s1_data <= rd_word;
          end
          rvalid <= s1_valid;
          if (s1_valid) begin
            rdata <= s1_data;
          end
        end
      end
    end else begin : g_lat1
      // Single-stage read; rdata holds its last value between strobes
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata  <= '0;
          rvalid <= 1'b0;
        end else begin
          rvalid <= rd_en;
          if (rd_en) begin
            rdata <= rd_word;
          end
        end
      end
    end
  endgenerate

endmodule

// File: doc/sram_dp_param.md
Name: sram_dp_param

Overview:
- Parametrised simple-dual-port SRAM model with one write port and one read port.
- Generalises the fixed 8k x 32 buffer: configurable width/depth, per-byte write mask, 1- or 2-cycle read pipeline with rvalid, selectable write/read collision policy, and a post-reset zero-fill sweep with init_done.
- Sits between the DMA/loader and the conv accelerator as its ifmap/weight store.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 8192, number of words; power of two.
- ADDR_W, $clog2(DEPTH), address width (derived).
- READ_LAT, 1, read latency in cycles; legal values 1 or 2.
- WRITE_FIRST, 1, 1 = same-cycle same-address read returns new data; 0 = returns old data.
- INIT_ZERO, 1, 1 = zero-fill all words after reset; 0 = no sweep.

Ports:
- clk, input, 1, clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset.
- wsbn, input, 1, write enable, active low.
- waddr, input, ADDR_W, write address.
- wdata, input, DATA_W, write data.
- wmask, input, DATA_W/8, byte enables for the write, active high.
- csbn, input, 1, read enable, active low.
- raddr, input, ADDR_W, read address.
- rdata, output, DATA_W, read data.
- rvalid, output, 1, rdata valid strobe.
- init_done, output, 1, high once the array is ready for access.

Behaviour:
- Reset (rst=1 at a clock edge): rdata=0, rvalid=0, all read-pipeline stages cleared, init_done=0, init counter=0. Memory contents are not touched by reset itself.
- Init FSM states:
  - INIT: entered from reset when INIT_ZERO=1. Writes 0 to address cnt each cycle; cnt increments from 0 to DEPTH-1. After writing DEPTH-1, the next state is READY.
  - READY: init_done=1. With INIT_ZERO=0, READY is entered on the first cycle after rst deasserts.
- The sweep takes exactly DEPTH cycles. init_done rises on the edge after the write of DEPTH-1.
- In INIT, wsbn/csbn are ignored: no user write, no read issued, rvalid stays 0.
- Reset asserted mid-INIT restarts the sweep from address 0.
- Write (READY, wsbn=0): for each byte b with wmask[b]=1, mem[waddr][8b+7:8b] <= wdata[8b+7:8b]. Unmasked bytes are unchanged. wmask=0 is a no-op.
- Read (READY, csbn=0): a request is captured at edge T.
  - READ_LAT=1: rdata and rvalid=1 appear after edge T.
  - READ_LAT=2: rdata and rvalid=1 appear after edge T+1.
  - Back-to-back reads give one result per cycle, in order.
- rvalid is a single-cycle strobe per request. rdata holds its last value when rvalid=0.
- Collision (same edge, wsbn=0, csbn=0, waddr==raddr):
  - WRITE_FIRST=1: returned data is the merged word, i.e. wdata for masked bytes and old contents for the rest.
  - WRITE_FIRST=0: returned data is the pre-write contents.
  - Different addresses: no interaction.
- A write at edge T is visible to any read captured at edge T+1 or later.
- Address width is exact, so no out-of-range access is possible. Addresses do not wrap; each port uses only its own supplied address.
- Reset asserted while reads are in flight: pending results are discarded and rvalid=0 from the next cycle.

Test Plan:
- DEPTH=16, INIT_ZERO=1: pulse rst for 1 cycle -> init_done=0 for exactly 16 cycles, then 1. A read of address 5 then returns 0x00000000 with rvalid.
- READY: write 0xDEADBEEF to address 3 with wmask=4'hF, then write 0x11223344 with wmask=4'b0101 -> read of address 3 returns 0xDE22BE44.
- READ_LAT=2: reads of addresses 1, 2, 3 on consecutive cycles (contents 0xA, 0xB, 0xC) -> rvalid high on 3 consecutive cycles starting 2 cycles after the first request, data 0xA, 0xB, 0xC.
- Collision at address 7 (old 0x0, write 0xCAFEF00D, mask 4'hF) -> WRITE_FIRST=1 returns 0xCAFEF00D; WRITE_FIRST=0 returns 0x0. A follow-up read returns 0xCAFEF00D in both cases.
- rst asserted at sweep cycle 8 of 16 -> counter restarts, init_done rises 16 cycles after rst deasserts. User write during INIT (wsbn=0, address 2, 0xFF) has no effect: address 2 later reads 0.
- rst with a READ_LAT=2 read in flight -> no rvalid pulse for that read, and rdata=0 after reset.
